// File: rtl/hmr_dmr_recovery_seq_if.sv
// Signal bundle between the recovery sequencer and its environment
// (DMR control FSM, core debug ports, backup RF and restore ports).
interface hmr_dmr_recovery_seq_if #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned RfAddrWidth = 5
);
  logic                   recovery_request_i;
  logic                   recovery_finished_o;
  logic                   debug_halt_req_o;
  logic                   debug_resume_o;
  logic [1:0]             cores_halted_i;
  logic                   instr_lock_o;
  logic [RfAddrWidth-1:0] rf_backup_raddr_o;
  logic                   rf_backup_re_o;
  logic [DataWidth-1:0]   rf_backup_rdata_i;
  logic                   rf_restore_we_o;
  logic [RfAddrWidth-1:0] rf_restore_addr_o;
  logic [DataWidth-1:0]   rf_restore_data_o;
  logic [DataWidth-1:0]   pc_backup_i;
  logic                   pc_restore_we_o;
  logic [DataWidth-1:0]   pc_restore_o;
  logic                   busy_o;

  // Sequencer side
  modport master (
    input  recovery_request_i, cores_halted_i, rf_backup_rdata_i, pc_backup_i,
    output recovery_finished_o, debug_halt_req_o, debug_resume_o, instr_lock_o,
           rf_backup_raddr_o, rf_backup_re_o, rf_restore_we_o, rf_restore_addr_o,
           rf_restore_data_o, pc_restore_we_o, pc_restore_o, busy_o
  );

  // Environment side
  modport slave (
    output recovery_request_i, cores_halted_i, rf_backup_rdata_i, pc_backup_i,
    input  recovery_finished_o, debug_halt_req_o, debug_resume_o, instr_lock_o,
           rf_backup_raddr_o, rf_backup_re_o, rf_restore_we_o, rf_restore_addr_o,
           rf_restore_data_o, pc_restore_we_o, pc_restore_o, busy_o
  );
endinterface

// File: rtl/hmr_dmr_recovery_seq.sv
// Rapid-recovery sequencer for one DMR group: halt both cores, restore the
// register file from backup (entries 1..NumRegs-1), restore the PC, resume.
module hmr_dmr_recovery_seq #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumRegs     = 32,
  parameter int unsigned RfAddrWidth = $clog2(NumRegs)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  hmr_dmr_recovery_seq_if.master  bus
);

  localparam logic [RfAddrWidth-1:0] LastAddr = RfAddrWidth'(NumRegs - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    RF_RESTORE,
    PC_RESTORE,
    RESUME,
    DONE
  } state_e;

  state_e                 state;
  logic                   finished;
  logic                   halt_req;
  logic                   resume;
  logic                   lock;
  logic                   rd_en;
  logic [RfAddrWidth-1:0] rd_addr;
  logic                   wr_en;
  logic [RfAddrWidth-1:0] wr_addr;
  logic                   pc_we;

  // Sequencer FSM; every control output is a flop updated with the state.
  // rd_addr doubles as the read counter; the write stage is the read stage
  // delayed by one cycle so it lines up with the backup RF read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      finished <= 1'b0;
      halt_req <= 1'b0;
      resume   <= 1'b0;
      lock     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      pc_we    <= 1'b0;
    end else begin
      finished <= 1'b0;
      pc_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.recovery_request_i) begin
            state    <= HALT;
            halt_req <= 1'b1;
            lock     <= 1'b1;
          end
        end
        HALT: begin
          if (bus.cores_halted_i == 2'b11) begin
            state   <= RF_RESTORE;
            rd_en   <= 1'b1;
            rd_addr <= RfAddrWidth'(1);
          end
        end
        RF_RESTORE: begin
          wr_en   <= rd_en;
          wr_addr <= rd_en ? rd_addr : '0;
          if (rd_en) begin
            if (rd_addr == LastAddr) begin
              rd_en   <= 1'b0;
              rd_addr <= '0;
            end else begin
              rd_addr <= rd_addr + RfAddrWidth'(1);
            end
          end
          if (wr_en && (wr_addr == LastAddr)) begin
            state   <= PC_RESTORE;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            pc_we   <= 1'b1;
          end
        end
        PC_RESTORE: begin
          state    <= RESUME;
          halt_req <= 1'b0;
          resume   <= 1'b1;
        end
        RESUME: begin
          if (bus.cores_halted_i == 2'b00) begin
            state    <= DONE;
            resume   <= 1'b0;
            finished <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          lock  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          halt_req <= 1'b0;
          resume   <= 1'b0;
          lock     <= 1'b0;
          rd_en    <= 1'b0;
          rd_addr  <= '0;
          wr_en    <= 1'b0;
          wr_addr  <= '0;
        end
      endcase
    end
  end

  assign bus.recovery_finished_o = finished;
  assign bus.debug_halt_req_o    = halt_req;
  assign bus.debug_resume_o      = resume;
  assign bus.instr_lock_o        = lock;
  assign bus.rf_backup_re_o      = rd_en;
  assign bus.rf_backup_raddr_o   = rd_addr;
  assign bus.rf_restore_we_o     = wr_en;
  assign bus.rf_restore_addr_o   = wr_addr;
  // Backup data arrives the cycle after the read, i.e. in the write cycle.
  assign bus.rf_restore_data_o   = wr_en ? bus.rf_backup_rdata_i : '0;
  assign bus.pc_restore_we_o     = pc_we;
  assign bus.pc_restore_o        = pc_we ? bus.pc_backup_i : '0;
  assign bus.busy_o              = (state != IDLE);

endmodule

// File: tb/tb_hmr_dmr_recovery_seq.sv
// Self-checking bench for hmr_dmr_recovery_seq (NumRegs=32, DataWidth=32).
module tb_hmr_dmr_recovery_seq;

  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  hmr_dmr_recovery_seq_if #(.DataWidth(32), .RfAddrWidth(5)) bus ();

  hmr_dmr_recovery_seq #(.DataWidth(32), .NumRegs(NR), .RfAddrWidth(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct { int cyc; int addr; logic [31:0] data; } wr_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] mem [NR];
  wr_t  wr_q[$];
  int   rd_q[$];
  int   pc_cyc_q[$];
  logic [31:0] pc_val_q[$];
  int   fin_q[$];
  int   h_q[$];
  int   r_q[$];
  int   hs_q[$];
  int   gate_err;

  bit   auto_core = 1'b1;
  int   halt_delay = 1, resume_delay = 1;
  int   hcnt, rcnt;
  int   drop_after = 1;
  bit   prev_re, prev_fin, prev_halt;
  int   prev_raddr;

  // Every DUT output concatenated; zero means "reset values"
  function automatic logic [120:0] all_outs();
    return {bus.recovery_finished_o, bus.debug_halt_req_o, bus.debug_resume_o,
            bus.instr_lock_o, bus.rf_backup_raddr_o, bus.rf_backup_re_o,
            bus.rf_restore_we_o, bus.rf_restore_addr_o, bus.rf_restore_data_o,
            bus.pc_restore_we_o, bus.pc_restore_o, bus.busy_o};
  endfunction

  task automatic clear_logs();
    wr_q.delete(); rd_q.delete(); pc_cyc_q.delete(); pc_val_q.delete();
    fin_q.delete(); h_q.delete(); r_q.delete(); hs_q.delete();
    gate_err = 0; hcnt = 0; rcnt = 0;
  endtask

  // One clock cycle: act as backup RF, upstream FSM and the two cores,
  // then record what the DUT did in this cycle.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    bus.rf_backup_rdata_i = prev_re ? mem[prev_raddr] : 32'h0;
    if (prev_fin && fin_q.size() >= drop_after) bus.recovery_request_i = 1'b0;
    if (auto_core) begin
      if (bus.debug_halt_req_o && bus.cores_halted_i != 2'b11) begin
        hcnt++;
        if (hcnt >= halt_delay) begin
          bus.cores_halted_i = 2'b11; h_q.push_back(cyc); rcnt = 0;
        end
      end else if (bus.debug_resume_o && bus.cores_halted_i != 2'b00) begin
        rcnt++;
        if (rcnt >= resume_delay) begin
          bus.cores_halted_i = 2'b00; r_q.push_back(cyc); hcnt = 0;
        end
      end
    end
    #1;
    if (bus.rf_restore_we_o)
      wr_q.push_back('{cyc, int'(bus.rf_restore_addr_o), bus.rf_restore_data_o});
    else if (bus.rf_restore_addr_o != 0 || bus.rf_restore_data_o != 0) gate_err++;
    if (bus.pc_restore_we_o) begin
      pc_cyc_q.push_back(cyc); pc_val_q.push_back(bus.pc_restore_o);
    end else if (bus.pc_restore_o != 0) gate_err++;
    if (bus.rf_backup_re_o) rd_q.push_back(int'(bus.rf_backup_raddr_o));
    if (bus.recovery_finished_o) fin_q.push_back(cyc);
    if (bus.debug_halt_req_o && !prev_halt) hs_q.push_back(cyc);
    prev_halt  = bus.debug_halt_req_o;
    prev_re    = bus.rf_backup_re_o;
    prev_raddr = int'(bus.rf_backup_raddr_o);
    prev_fin   = bus.recovery_finished_o;
  endtask

  task automatic run_until_fin(input int n, input int budget, input string name);
    int k = 0;
    while (fin_q.size() < n && k < budget) begin tick(); k++; end
    if (fin_q.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got %0d finished pulses, expected %0d within %0d cycles",
               name, fin_q.size(), n, budget);
    end
    tick(); tick();
  endtask

  task automatic fill_mem(input bit pattern);
    for (int a = 0; a < NR; a++) mem[a] = pattern ? (32'hA000_0000 + a) : $urandom();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    clear_logs();
    rst_ni = 1'b0;
    bus.recovery_request_i = 1'b1;
    bus.cores_halted_i = 2'b00;
    bus.pc_backup_i = 32'h1234_5678;
    bus.rf_backup_rdata_i = '0;
    halt_delay = 2; resume_delay = 1;
    fill_mem(1'b0);
    tick(); tick();
    n_tests++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    rst_ni = 1'b1;
    tick();
    n_tests++;
    if ({bus.debug_halt_req_o, bus.instr_lock_o, bus.busy_o} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release_halt: got %b expected 111",
               {bus.debug_halt_req_o, bus.instr_lock_o, bus.busy_o});
    end
    run_until_fin(1, 200, "reset_release");
    n_tests++;
    if (wr_q.size() != NR - 1) begin
      n_fail++; $display("FAIL reset_release_writes: got %0d expected %0d", wr_q.size(), NR-1);
    end
  endtask

  task automatic test_recovery();
    int c0, h;
    clear_logs();
    fill_mem(1'b1);
    bus.pc_backup_i = 32'h1C00_0080;
    halt_delay = 3; resume_delay = 1;
    bus.recovery_request_i = 1'b1; c0 = cyc;
    run_until_fin(1, 200, "recovery");
    h = (h_q.size() > 0) ? h_q[0] : -1;
    n_tests++;
    if (h != c0 + 3) begin
      n_fail++; $display("FAIL recovery_halt_ack: got cycle %0d expected %0d", h, c0+3);
    end
    n_tests++;
    if (wr_q.size() != NR - 1 || rd_q.size() != NR - 1) begin
      n_fail++;
      $display("FAIL recovery_count: got %0d writes %0d reads expected %0d",
               wr_q.size(), rd_q.size(), NR-1);
    end
    for (int a = 1; a < NR && a <= wr_q.size(); a++) begin
      n_tests++;
      if (wr_q[a-1].addr != a || wr_q[a-1].data !== 32'hA000_0000 + a ||
          wr_q[a-1].cyc != h + 1 + a || (a <= rd_q.size() && rd_q[a-1] != a)) begin
        n_fail++;
        $display("FAIL recovery_write%0d: got addr %0d data %h cyc %0d expected addr %0d data %h cyc %0d",
                 a, wr_q[a-1].addr, wr_q[a-1].data, wr_q[a-1].cyc, a, 32'hA000_0000 + a, h+1+a);
      end
    end
    n_tests++;
    if (pc_cyc_q.size() != 1 || pc_val_q[0] !== 32'h1C00_0080 || pc_cyc_q[0] != h + NR + 1) begin
      n_fail++;
      $display("FAIL recovery_pc: got %0d writes first %h at %0d expected 1 write 1c000080 at %0d",
               pc_cyc_q.size(), (pc_val_q.size() > 0) ? pc_val_q[0] : 32'h0,
               (pc_cyc_q.size() > 0) ? pc_cyc_q[0] : -1, h + NR + 1);
    end
    n_tests++;
    if (r_q.size() != 1 || r_q[0] != h + NR + 2 || fin_q.size() != 1 || fin_q[0] != r_q[0] + 1) begin
      n_fail++;
      $display("FAIL recovery_finish: got %0d pulses first at %0d expected 1 at %0d",
               fin_q.size(), (fin_q.size() > 0) ? fin_q[0] : -1, h + NR + 3);
    end
    n_tests++;
    if (bus.busy_o !== 1'b0 || bus.instr_lock_o !== 1'b0 || gate_err != 0) begin
      n_fail++;
      $display("FAIL recovery_idle: got busy %b lock %b gate_err %0d expected 0 0 0",
               bus.busy_o, bus.instr_lock_o, gate_err);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int c0, h;
      logic [31:0] pc;
      bit ok;
      clear_logs();
      fill_mem(1'b0);
      pc = $urandom();
      bus.pc_backup_i = pc;
      halt_delay   = (it == 0) ? 1 : int'($urandom_range(1, 6));
      resume_delay = (it == 0) ? 1 : int'($urandom_range(1, 4));
      bus.recovery_request_i = 1'b1; c0 = cyc;
      run_until_fin(1, 200, "random");
      h = (h_q.size() > 0) ? h_q[0] : -1;
      ok = (wr_q.size() == NR - 1);
      for (int a = 1; ok && a < NR; a++)
        if (wr_q[a-1].addr != a || wr_q[a-1].data !== mem[a] || wr_q[a-1].cyc != h + 1 + a) ok = 0;
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL random%0d_writes: got %0d writes, contents differ from backup", it, wr_q.size());
      end
      n_tests++;
      if (pc_val_q.size() != 1 || pc_val_q[0] !== pc || pc_cyc_q[0] != h + NR + 1) begin
        n_fail++; $display("FAIL random%0d_pc: got %0d writes expected one of %h", it, pc_val_q.size(), pc);
      end
      n_tests++;
      if (fin_q.size() != 1 || fin_q[0] != h + NR + 2 + resume_delay) begin
        n_fail++;
        $display("FAIL random%0d_finish: got %0d pulses at %0d expected 1 at %0d", it, fin_q.size(),
                 (fin_q.size() > 0) ? fin_q[0] : -1, h + NR + 2 + resume_delay);
      end
      if (it == 0) begin
        n_tests++;
        if (fin_q.size() < 1 || fin_q[0] - c0 != NR + 4) begin
          n_fail++;
          $display("FAIL min_latency: got %0d expected %0d",
                   (fin_q.size() > 0) ? fin_q[0] - c0 : -1, NR + 4);
        end
      end
    end
  endtask

  task automatic test_single_core();
    int h;
    clear_logs();
    fill_mem(1'b0);
    bus.pc_backup_i = $urandom();
    auto_core = 1'b0;
    bus.cores_halted_i = 2'b00;
    bus.recovery_request_i = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) begin
      bus.cores_halted_i = (i < 25) ? 2'b01 : 2'b10;
      tick();
    end
    n_tests++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || bus.debug_halt_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_core_stall: got %0d reads %0d writes halt_req %b expected 0 0 1",
               rd_q.size(), wr_q.size(), bus.debug_halt_req_o);
    end
    bus.cores_halted_i = 2'b11; h = cyc;
    auto_core = 1'b1;
    run_until_fin(1, 200, "single_core");
    n_tests++;
    if (wr_q.size() != NR - 1 || wr_q[0].cyc != h + 2 || wr_q[0].addr != 1 || fin_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_core_resume: got %0d writes first at %0d, %0d pulses expected %0d at %0d, 1",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0].cyc : -1, fin_q.size(), NR-1, h+2);
    end
  endtask

  task automatic test_req_drop();
    int k = 0;
    clear_logs();
    fill_mem(1'b0);
    bus.pc_backup_i = $urandom();
    halt_delay = 2; resume_delay = 2;
    bus.recovery_request_i = 1'b1;
    while (wr_q.size() < 5 && k < 100) begin tick(); k++; end
    bus.recovery_request_i = 1'b0;
    run_until_fin(1, 200, "req_drop");
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (wr_q.size() != NR - 1 || pc_val_q.size() != 1 || pc_val_q[0] !== bus.pc_backup_i ||
        fin_q.size() != 1 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL req_drop: got %0d writes %0d pc %0d pulses busy %b expected %0d 1 1 0",
               wr_q.size(), pc_val_q.size(), fin_q.size(), bus.busy_o, NR-1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    fill_mem(1'b0);
    bus.pc_backup_i = $urandom();
    halt_delay = 1; resume_delay = 1;
    drop_after = 2;
    bus.recovery_request_i = 1'b1;
    run_until_fin(2, 400, "back_to_back");
    for (int i = 0; i < 10; i++) tick();
    drop_after = 1;
    n_tests++;
    if (fin_q.size() != 2 || hs_q.size() != 2 || hs_q[1] != fin_q[0] + 2) begin
      n_fail++;
      $display("FAIL back_to_back_restart: got %0d pulses %0d halts second halt at %0d expected 2 2 at %0d",
               fin_q.size(), hs_q.size(), (hs_q.size() > 1) ? hs_q[1] : -1,
               (fin_q.size() > 0) ? fin_q[0] + 2 : -1);
    end
    ok = (wr_q.size() == 2 * (NR - 1)) && (pc_val_q.size() == 2);
    for (int i = 0; ok && i < 2 * (NR - 1); i++)
      if (wr_q[i].addr != (i % (NR - 1)) + 1 || wr_q[i].data !== mem[(i % (NR - 1)) + 1]) ok = 0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL back_to_back_writes: got %0d writes %0d pc writes expected %0d 2",
               wr_q.size(), pc_val_q.size(), 2 * (NR - 1));
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_logs();
    fill_mem(1'b0);
    bus.pc_backup_i = $urandom() | 32'h1;
    halt_delay = 2; resume_delay = 1;
    bus.recovery_request_i = 1'b1;
    while (wr_q.size() < 10 && k < 100) begin tick(); k++; end
    n_tests++;
    if (wr_q.size() != 10 || wr_q[9].addr != 10) begin
      n_fail++; $display("FAIL reset_mid_progress: got %0d writes expected 10", wr_q.size());
    end
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0", all_outs());
    end
    bus.recovery_request_i = 1'b0;
    bus.cores_halted_i = 2'b00;
    hcnt = 0; rcnt = 0;
    for (int i = 0; i < 4; i++) tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (fin_q.size() != 0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_finish: got %0d pulses busy %b expected 0 0", fin_q.size(), bus.busy_o);
    end
    clear_logs();
    bus.recovery_request_i = 1'b1;
    run_until_fin(1, 200, "reset_mid_restart");
    n_tests++;
    if (wr_q.size() != NR - 1 || wr_q[0].addr != 1 || wr_q[0].data !== mem[1] || fin_q.size() != 1) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got %0d writes first addr %0d, %0d pulses expected %0d 1 1",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0].addr : -1, fin_q.size(), NR-1);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    bus.recovery_request_i = 1'b0;
    bus.cores_halted_i = 2'b00;
    bus.rf_backup_rdata_i = '0;
    bus.pc_backup_i = '0;
    test_reset();
    test_recovery();
    test_random();
    test_single_core();
    test_req_drop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
